// File: rtl/noc_pkg.sv
// noc_pkg: shared types, constants and helpers for the NoC traffic PE.
// Holds the pattern-mode encodings, the generator FSM state type, the LFSR
// seed/taps and the packet-field width helpers.
package noc_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM  = 2'd0,
        MODE_TORNADO  = 2'd1,
        MODE_BITCOMP  = 2'd2,
        MODE_NEIGHBOR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          SEQ_WIDTH = 16;

    function automatic int pkt_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/noc_lfsr.sv
// noc_lfsr: 16-bit Galois LFSR with enable. Also exposes the next value so
// the caller can use it in the same cycle it advances the register.
module noc_lfsr
    import noc_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr,
    output logic [15:0] lfsr_nxt
);

    assign lfsr_nxt = lfsr_step(lfsr);

    // Shift register: reload seed on reset, step only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: synthetic traffic generator / sink for a NoC endpoint.
// Injects PKT_LIMIT packets using a selectable destination pattern and counts
// received packets, flagging misrouted ones.
// Optional feature: define NOC_PE_RX_THROTTLE_EN to deassert o_data_ready one
// cycle in four (free-running 2-bit counter).
//
// state | meaning
// IDLE  | waiting for i_start
// SEND  | packet presented on TX, waiting for handshake
// GAP   | counting idle cycles before the next packet
// DONE  | PKT_LIMIT packets sent; absorbing until reset
module noc_traffic_pe
    import noc_pkg::*;
#(
    parameter int          ADDRESS    = 0,
    parameter int          NUM_PE     = 8,
    parameter int          ADDR_WIDTH = $clog2(NUM_PE),
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned PKT_LIMIT  = 100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [1:0]                       i_mode,
    input  logic [7:0]                       i_gap,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_data,
    output logic                             o_data_valid,
    input  logic                             i_data_ready,
    input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] i_data,
    input  logic                             i_data_valid,
    output logic                             o_data_ready,
    output logic [31:0]                      o_sent_cnt,
    output logic [31:0]                      o_rcvd_cnt,
    output logic [15:0]                      o_err_cnt,
    output logic                             o_done
);

    localparam int PW = pkt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OWN_ADDR     = ADDR_WIDTH'(ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] TORNADO_ADDR = ADDR_WIDTH'(ADDRESS + NUM_PE / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] BITCOMP_ADDR = ~OWN_ADDR;
    localparam logic [ADDR_WIDTH-1:0] NEIGH_ADDR   = ADDR_WIDTH'(ADDRESS + 1);
    localparam logic [31:0]           LAST_IDX     = PKT_LIMIT - 1;
    localparam logic [15:0]           SEED         = LFSR_SEED ^ 16'(ADDRESS);

    state_e                state, state_nxt;
    logic                  tx_hs, rx_hs;
    logic                  load_pkt, use_nxt;
    logic [7:0]            gap_q, gap_cnt;
    logic [15:0]           lfsr, lfsr_nxt, pick_lfsr;
    logic [ADDR_WIDTH-1:0] uni_addr, dest_nxt, rx_dest;
    logic [15:0]           seq_nxt;
    logic [PW-1:0]         pkt_nxt;
    logic                  unused_bits;

    assign o_data_valid = (state == ST_SEND);
    assign o_done       = (state == ST_DONE);
    assign tx_hs        = o_data_valid & i_data_ready;
    assign rx_hs        = i_data_valid & o_data_ready;
    assign rx_dest      = i_data[PW-1 -: ADDR_WIDTH];
    assign unused_bits  = ^{pick_lfsr[15:ADDR_WIDTH], i_data[DATA_WIDTH-1:0]};

    noc_lfsr #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (tx_hs),
        .lfsr     (lfsr),
        .lfsr_nxt (lfsr_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; load_pkt marks every SEND entry, use_nxt the entries
    // that coincide with a handshake (LFSR and seq advance on the same edge).
    always_comb begin
        state_nxt = state;
        load_pkt  = 1'b0;
        use_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_SEND;
                    load_pkt  = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_hs) begin
                    if (o_sent_cnt == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else if (gap_q != 8'd0) begin
                        state_nxt = ST_GAP;
                    end else begin
                        load_pkt = 1'b1;
                        use_nxt  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_nxt = ST_SEND;
                    load_pkt  = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Destination and payload for the packet about to be presented.
    always_comb begin
        pick_lfsr = use_nxt ? lfsr_nxt : lfsr;
        uni_addr  = pick_lfsr[ADDR_WIDTH-1:0];
        if (uni_addr == OWN_ADDR) begin
            uni_addr = uni_addr + ADDR_WIDTH'(1);
        end
        dest_nxt = uni_addr;
        case (mode_e'(i_mode))
            MODE_TORNADO:  dest_nxt = TORNADO_ADDR;
            MODE_BITCOMP:  dest_nxt = BITCOMP_ADDR;
            MODE_NEIGHBOR: dest_nxt = NEIGH_ADDR;
            default:       dest_nxt = uni_addr;
        endcase
        seq_nxt = use_nxt ? 16'(o_sent_cnt + 32'd1) : o_sent_cnt[15:0];
        pkt_nxt = '0;
        pkt_nxt[PW-1 -: ADDR_WIDTH]         = dest_nxt;
        pkt_nxt[DATA_WIDTH-1 -: ADDR_WIDTH] = OWN_ADDR;
        pkt_nxt[SEQ_WIDTH-1:0]              = seq_nxt;
    end

    // Packet register and gap sample, both captured only at SEND entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
            gap_q  <= '0;
        end else if (load_pkt) begin
            o_data <= pkt_nxt;
            gap_q  <= i_gap;
        end
    end

    // Idle-gap down-counter; SEND resumes on the terminal count of 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == ST_SEND && state_nxt == ST_GAP) begin
            gap_cnt <= gap_q;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Traffic counters; TX and RX are independent and may count together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sent_cnt <= '0;
            o_rcvd_cnt <= '0;
            o_err_cnt  <= '0;
        end else begin
            if (tx_hs) begin
                o_sent_cnt <= o_sent_cnt + 32'd1;
            end
            if (rx_hs) begin
                o_rcvd_cnt <= o_rcvd_cnt + 32'd1;
            end
            if (rx_hs && rx_dest != OWN_ADDR && o_err_cnt != 16'hFFFF) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end

`ifdef NOC_PE_RX_THROTTLE_EN
    logic [1:0] thr_cnt;

    // RX ready drops for the cycle in which the free-running count reads 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_cnt      <= '0;
            o_data_ready <= 1'b0;
        end else begin
            thr_cnt      <= thr_cnt + 2'd1;
            o_data_ready <= (thr_cnt != 2'd2);
        end
    end
`else
    // RX always ready once out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data_ready <= 1'b0;
        end else begin
            o_data_ready <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_traffic_pe.sv
// tb_noc_traffic_pe: self-checking bench for noc_traffic_pe (NUM_PE=8,
// ADDRESS=2). A second instance with a large packet limit exercises the
// uniform-random pattern.
`timescale 1ns/1ps
module tb_noc_traffic_pe;

    localparam int A    = 2;
    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int DW   = 32;
    localparam int PW   = AW + DW;
    localparam int LIM  = 4;
    localparam int ULIM = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, start_u;
    logic [1:0]    mode, mode_u;
    logic [7:0]    gap, gap_u;
    logic [PW-1:0] tx_data, tx_data_u, rx_data, rx_data_u;
    logic          tx_valid, tx_valid_u, tx_ready, tx_ready_u;
    logic          rx_valid, rx_valid_u, rx_ready, rx_ready_u;
    logic [31:0]   sent, sent_u, rcvd, rcvd_u;
    logic [15:0]   err, err_u;
    logic          done, done_u;

    int checks   = 0;
    int errors   = 0;
    int exp_rcvd = 0;
    int exp_err  = 0;

    noc_traffic_pe #(.ADDRESS(A), .NUM_PE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PKT_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_mode(mode), .i_gap(gap),
        .o_data(tx_data), .o_data_valid(tx_valid), .i_data_ready(tx_ready),
        .i_data(rx_data), .i_data_valid(rx_valid), .o_data_ready(rx_ready),
        .o_sent_cnt(sent), .o_rcvd_cnt(rcvd), .o_err_cnt(err), .o_done(done)
    );

    noc_traffic_pe #(.ADDRESS(A), .NUM_PE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PKT_LIMIT(ULIM)) dut_u (
        .clk(clk), .rst(rst), .i_start(start_u), .i_mode(mode_u), .i_gap(gap_u),
        .o_data(tx_data_u), .o_data_valid(tx_valid_u), .i_data_ready(tx_ready_u),
        .i_data(rx_data_u), .i_data_valid(rx_valid_u), .o_data_ready(rx_ready_u),
        .o_sent_cnt(sent_u), .o_rcvd_cnt(rcvd_u), .o_err_cnt(err_u), .o_done(done_u)
    );

    // Reference model: destination per pattern from plain arithmetic.
    function automatic int exp_dest(input int m);
        case (m)
            1:       return (A + N / 2 - 1) % N;
            2:       return N - 1 - A;
            3:       return (A + 1) % N;
            default: return 0;
        endcase
    endfunction

    function automatic logic [PW-1:0] exp_pkt(input int d, input int seq);
        logic [PW-1:0] p = '0;
        p[PW-1 -: AW] = AW'(d);
        p[DW-1 -: AW] = AW'(A);
        p[15:0]       = 16'(seq);
        return p;
    endfunction

    task automatic do_reset();
        start = 0; start_u = 0; rx_valid = 0; rx_valid_u = 0;
        tx_ready = 1; tx_ready_u = 1; rx_data = '0; rx_data_u = '0;
        @(negedge clk); rst = 1;
        @(negedge clk); @(negedge clk); rst = 0;
        exp_rcvd = 0; exp_err = 0;
    endtask

    task automatic rx_send(input int d);
        int n = 0;
        rx_data  = {AW'(d), DW'($urandom)};
        rx_valid = 1;
        while (!rx_ready && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (n >= 8) begin errors++; $display("FAIL rx_timeout: ready never seen in %0d cycles", n); end
        @(negedge clk);
        rx_valid = 0;
        exp_rcvd++;
        if (d != A && exp_err < 65535) exp_err++;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; start_u = 0; mode = 0; mode_u = 0; gap = 0; gap_u = 0;
        tx_ready = 1; tx_ready_u = 1; rx_valid = 0; rx_valid_u = 0; rx_data = '0; rx_data_u = '0;
        #12;
        checks++; if (tx_data !== '0)   begin errors++; $display("FAIL rst_data: got %h want 0", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
        checks++; if (sent !== 32'd0 || rcvd !== 32'd0 || err !== 16'd0) begin
            errors++; $display("FAIL rst_counters: sent %0d rcvd %0d err %0d want 0", sent, rcvd, err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", rx_ready); end
        @(negedge clk); rst = 0;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b want 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_tx_run(input string name, input int m, input int g, input bit rnd);
        int hs = 0, cyc = 0, idle = 0;
        bit fresh = 1;
        logic [PW-1:0] want;
        do_reset();
        mode = 2'(m); gap = 8'(g); tx_ready = 1; start = 1;
        @(negedge clk); start = 0;
        while (hs < LIM && cyc < 500) begin
            checks++;
            if (rcvd !== 32'(exp_rcvd) || err !== 16'(exp_err)) begin
                errors++; $display("FAIL %s rx_counts: rcvd %0d err %0d want %0d %0d", name, rcvd, err, exp_rcvd, exp_err); end
            if (rnd) begin
                tx_ready = ($urandom_range(0, 2) != 0);
                rx_valid = 1'($urandom_range(0, 1));
                rx_data  = {AW'($urandom_range(0, 7)), DW'($urandom)};
                start    = 1'($urandom_range(0, 1));
            end
            if (tx_valid) begin
                want = exp_pkt(exp_dest(m), hs);
                checks++;
                if (tx_data !== want) begin errors++; $display("FAIL %s data pkt %0d: got %h want %h", name, hs, tx_data, want); end
                checks++;
                if (sent !== 32'(hs)) begin errors++; $display("FAIL %s sent: got %0d want %0d", name, sent, hs); end
                if (fresh && hs > 0) begin
                    checks++;
                    if (idle != g) begin errors++; $display("FAIL %s gap: got %0d idle want %0d", name, idle, g); end
                end
                fresh = 0;
                if (tx_ready) begin hs++; idle = 0; fresh = 1; end
            end else begin
                idle++;
            end
            // Mode/gap may only change while a packet is stalled; they must be ignored.
            if (tx_valid && !tx_ready) begin mode = 2'($urandom); gap = 8'($urandom); end
            else begin mode = 2'(m); gap = 8'(g); end
            if (rx_valid && rx_ready) begin
                exp_rcvd++;
                if (rx_data[PW-1 -: AW] != AW'(A) && exp_err < 65535) exp_err++;
            end
            @(negedge clk); cyc++;
        end
        rx_valid = 0; start = 0;
        checks++; if (hs != LIM) begin errors++; $display("FAIL %s timeout: got %0d pkts want %0d", name, hs, LIM); end
        checks++; if (done !== 1'b1 || sent !== 32'(LIM) || tx_valid !== 1'b0) begin
            errors++; $display("FAIL %s done: done %b sent %0d valid %b want 1 %0d 0", name, done, sent, tx_valid, LIM); end
        checks++;
        if (rcvd !== 32'(exp_rcvd) || err !== 16'(exp_err)) begin
            errors++; $display("FAIL %s rx_final: rcvd %0d err %0d want %0d %0d", name, rcvd, err, exp_rcvd, exp_err); end
        start = 1; @(negedge clk); start = 0; @(negedge clk);
        checks++; if (done !== 1'b1 || sent !== 32'(LIM) || tx_valid !== 1'b0) begin
            errors++; $display("FAIL %s done_hold: done %b sent %0d valid %b", name, done, sent, tx_valid); end
    endtask

    task automatic test_stall();
        logic [PW-1:0] want;
        do_reset();
        mode = 3; gap = 0; tx_ready = 0; start = 1;
        @(negedge clk); start = 0;
        want = exp_pkt(3, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== want || sent !== 32'd0) begin
                errors++; $display("FAIL stall cyc %0d: valid %b data %h sent %0d want 1 %h 0", i, tx_valid, tx_data, sent, want); end
            mode = (i < 4) ? 2'd1 : 2'd3;
            @(negedge clk);
        end
        tx_ready = 1; @(negedge clk); tx_ready = 0;
        want = exp_pkt(3, 1);
        checks++;
        if (sent !== 32'd1 || tx_valid !== 1'b1 || tx_data !== want) begin
            errors++; $display("FAIL stall_release: sent %0d valid %b data %h want 1 1 %h", sent, tx_valid, tx_data, want); end
        @(negedge clk);
        checks++; if (sent !== 32'd1) begin errors++; $display("FAIL stall_single: sent %0d want 1", sent); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [PW-1:0] want;
        do_reset();
        rx_send(2); rx_send(6);
        mode = 1; gap = 2; tx_ready = 1; start = 1;
        @(negedge clk); start = 0;
        while (sent !== 32'd2 && n < 40) begin @(negedge clk); n++; end
        checks++; if (sent !== 32'd2) begin errors++; $display("FAIL mid_timeout: sent %0d want 2", sent); end
        #2 rst = 1;
        #1;
        checks++;
        if (tx_data !== '0 || tx_valid !== 1'b0 || done !== 1'b0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out: data %h valid %b done %b ready %b want 0", tx_data, tx_valid, done, rx_ready); end
        checks++;
        if (sent !== 32'd0 || rcvd !== 32'd0 || err !== 16'd0) begin
            errors++; $display("FAIL mid_rst_cnt: sent %0d rcvd %0d err %0d want 0", sent, rcvd, err); end
        @(negedge clk); rst = 0; exp_rcvd = 0; exp_err = 0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_abort: valid %b want 0", tx_valid); end
        end
        gap = 0; start = 1;
        @(negedge clk); start = 0;
        want = exp_pkt(5, 0);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== want || sent !== 32'd0) begin
            errors++; $display("FAIL mid_restart: valid %b data %h sent %0d want 1 %h 0", tx_valid, tx_data, sent, want); end
    endtask

    task automatic test_rx();
        int d;
        do_reset();
        rx_send(2); rx_send(6);
        checks++; if (rcvd !== 32'd2 || err !== 16'd1) begin
            errors++; $display("FAIL rx_basic: rcvd %0d err %0d want 2 1", rcvd, err); end
        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 7);
            rx_send(d);
            checks++;
            if (rcvd !== 32'(exp_rcvd) || err !== 16'(exp_err)) begin
                errors++; $display("FAIL rx_rand %0d: rcvd %0d err %0d want %0d %0d", i, rcvd, err, exp_rcvd, exp_err); end
        end
    endtask

    task automatic test_uniform();
        int hs = 0, cyc = 0, d;
        bit seen[N];
        logic [PW-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) seen[i] = 0;
        mode_u = 0; gap_u = 0; tx_ready_u = 1; start_u = 1;
        @(negedge clk); start_u = 0;
        while (hs < ULIM && cyc < 1200) begin
            if (tx_valid_u) begin
                d = int'(tx_data_u[PW-1 -: AW]);
                want = exp_pkt(0, hs);
                checks++;
                if (d == A) begin errors++; $display("FAIL uni_self: pkt %0d dest %0d", hs, d); end
                checks++;
                if (tx_data_u[DW-1:0] !== want[DW-1:0]) begin
                    errors++; $display("FAIL uni_payload pkt %0d: got %h want %h", hs, tx_data_u[DW-1:0], want[DW-1:0]); end
                seen[d] = 1;
                hs++;
            end
            @(negedge clk); cyc++;
        end
        checks++; if (hs != ULIM) begin errors++; $display("FAIL uni_timeout: got %0d want %0d", hs, ULIM); end
        for (int i = 0; i < N; i++) begin
            if (i != A) begin
                checks++;
                if (!seen[i]) begin errors++; $display("FAIL uni_cover: dest %0d seen 0 want 1", i); end
            end
        end
        checks++;
        if (done_u !== 1'b1 || sent_u !== 32'(ULIM) || rcvd_u !== 32'd0 || err_u !== 16'd0 || rx_ready_u !== 1'b1 && rx_ready_u !== 1'b0) begin
            errors++; $display("FAIL uni_done: done %b sent %0d rcvd %0d err %0d", done_u, sent_u, rcvd_u, err_u); end
    endtask

    task automatic test_throttle();
        bit r[40];
        do_reset();
        for (int i = 0; i < 40; i++) begin @(negedge clk); r[i] = rx_ready; end
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL thr_first: got %b want 1", r[0]); end
`ifdef NOC_PE_RX_THROTTLE_EN
        begin
            int f = -1;
            for (int i = 3; i >= 0; i--) if (!r[i]) f = i;
            checks++; if (f < 0) begin errors++; $display("FAIL thr_phase: no low in first 4 cycles, got %b%b%b%b", r[0], r[1], r[2], r[3]); end
            else begin
                for (int i = f; i < 40; i++) begin
                    checks++;
                    if (r[i] !== (((i - f) % 4) != 0)) begin
                        errors++; $display("FAIL thr_pattern cyc %0d: got %b want %b", i, r[i], ((i - f) % 4) != 0); end
                end
            end
        end
`else
        for (int i = 0; i < 40; i++) begin
            checks++; if (r[i] !== 1'b1) begin errors++; $display("FAIL ready_const cyc %0d: got %b want 1", i, r[i]); end
        end
`endif
    endtask

    task automatic test_err_saturation();
        int bad = 0, cyc = 0, want;
        do_reset();
        rx_data = {AW'(6), DW'(32'h1234)}; rx_valid = 1;
        while (bad < 70000 && cyc < 95000) begin
            if (bad % 10000 == 0 || (bad >= 65533 && bad <= 65537)) begin
                want = (bad > 65535) ? 65535 : bad;
                checks++;
                if (err !== 16'(want)) begin errors++; $display("FAIL sat_track at %0d: got %0d want %0d", bad, err, want); end
            end
            if (rx_ready) bad++;
            @(negedge clk); cyc++;
        end
        rx_valid = 0;
        checks++; if (bad != 70000) begin errors++; $display("FAIL sat_timeout: got %0d want 70000", bad); end
        checks++; if (err !== 16'hFFFF || rcvd !== 32'(bad)) begin
            errors++; $display("FAIL sat_final: err %h rcvd %0d want ffff %0d", err, rcvd, bad); end
    endtask

    initial begin
        test_reset();
        test_tx_run("tornado", 1, 0, 0);
        test_tx_run("bitcomp", 2, 3, 0);
        test_tx_run("neighbour", 3, 1, 0);
        test_stall();
        repeat (4) test_tx_run("random", $urandom_range(1, 3), $urandom_range(0, 6), 1);
        test_reset_mid();
        test_rx();
        test_uniform();
        test_throttle();
        test_err_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
